// File: rtl/spi_dev_reg_bridge_pkg.sv
// ----------------------------------------------------------------------------
// spi_dev_reg_bridge_pkg
// Shared definitions for the SPI-device-to-register-bus bridge: opcode
// defaults, idle shift-out byte, frame state encodings and pointer helper.
// No ports.
// ----------------------------------------------------------------------------
package spi_dev_reg_bridge_pkg;

    // Default burst opcodes (overridable on the top module).
    localparam logic [7:0] CMD_WR_DEFAULT = 8'h02;
    localparam logic [7:0] CMD_RD_DEFAULT = 8'h03;

    // Byte shifted out whenever no read data is ready.
    localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;

    // Frame state encodings.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CMD      = 3'd1;
    localparam logic [2:0] ST_ADDR     = 3'd2;
    localparam logic [2:0] ST_WR_DATA  = 3'd3;
    localparam logic [2:0] ST_RD_DUMMY = 3'd4;
    localparam logic [2:0] ST_RD_DATA  = 3'd5;
    localparam logic [2:0] ST_DISCARD  = 3'd6;

    // Register pointer advance; 8-bit arithmetic wraps FF -> 00.
    function automatic logic [7:0] ptr_next(input logic [7:0] ptr);
        return ptr + 8'd1;
    endfunction

endpackage

// File: rtl/spi_dev_bus_ctl.sv
// ----------------------------------------------------------------------------
// spi_dev_bus_ctl
// Register-bus handshake: accepts a request when idle, holds bus_cyc (and the
// latched address/data/direction) until bus_ack, then pulses done.
// Ports:
//   clk_slow, rst            clock, synchronous active-low reset
//   req, req_we              request strobe and direction (accepted if !busy)
//   req_addr, req_wdata      request address / write data
//   bus_*                    register bus master signals
//   busy                     a cycle is outstanding (== bus_cyc)
//   done, done_we            completion pulse and direction of that cycle
//   rd_data                  read data, valid with done && !done_we
// ----------------------------------------------------------------------------
module spi_dev_bus_ctl (
    input  logic       clk_slow,
    input  logic       rst,
    input  logic       req,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_cyc,
    input  logic [7:0] bus_rdata,
    input  logic       bus_ack,
    output logic       busy,
    output logic       done,
    output logic       done_we,
    output logic [7:0] rd_data
);

    // An ack is only meaningful while a cycle is outstanding; stray acks
    // (idle, or during reset) fall out here.
    assign done    = bus_cyc & bus_ack;
    assign done_we = bus_we;
    assign busy    = bus_cyc;
    assign rd_data = bus_rdata;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_slow) begin
        if (!rst) begin
            bus_cyc   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 8'h00;
            bus_wdata <= 8'h00;
        end else if (bus_cyc) begin
            if (bus_ack) begin
                bus_cyc <= 1'b0;
                bus_we  <= 1'b0;
            end
        end else if (req) begin
            bus_cyc   <= 1'b1;
            bus_we    <= req_we;
            bus_addr  <= req_addr;
            bus_wdata <= req_wdata;
        end
    end

endmodule

// File: rtl/spi_dev_reg_bridge.sv
// ----------------------------------------------------------------------------
// spi_dev_reg_bridge
// Decodes SPI device byte frames (opcode, address, data...) into register bus
// write/read bursts with an auto-incrementing 8-bit pointer.
// Ports:
//   clk_slow, rst                       clock, synchronous active-low reset
//   spi_rx_data/spi_rx_stb              received byte and its strobe
//   spi_tx_data/spi_tx_ack              next byte to shift out, load pulse
//   spi_csn_rise/spi_csn_fall           chip-select edge pulses
//   bus_addr/bus_wdata/bus_we/bus_cyc   register bus request
//   bus_rdata/bus_ack                   register bus completion
//   err_ovr/err_udr                     sticky overrun / underrun flags
// ----------------------------------------------------------------------------
module spi_dev_reg_bridge
    import spi_dev_reg_bridge_pkg::*;
#(
    parameter logic [7:0] CMD_WR = CMD_WR_DEFAULT,
    parameter logic [7:0] CMD_RD = CMD_RD_DEFAULT
) (
    input  logic       clk_slow,
    input  logic       rst,
    input  logic [7:0] spi_rx_data,
    input  logic       spi_rx_stb,
    output logic [7:0] spi_tx_data,
    input  logic       spi_tx_ack,
    input  logic       spi_csn_rise,
    input  logic       spi_csn_fall,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_cyc,
    input  logic [7:0] bus_rdata,
    input  logic       bus_ack,
    output logic       err_ovr,
    output logic       err_udr
);

    logic [2:0] state;
    logic [7:0] ptr;
    logic [7:0] tx_reg;
    logic       is_read;
    logic       tx_valid;
    logic       rd_need;   // a read must be issued once the bus is free
    logic       stale;     // outstanding cycle belongs to an ended frame

    logic       req;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       busy;
    logic       done;
    logic       done_we;
    logic [7:0] rd_data;

    logic       cs_edge;
    logic       frame_done;
    logic       data_ack;

    assign cs_edge    = spi_csn_fall | spi_csn_rise;
    assign frame_done = done & ~stale;
    // The load pulse arriving with the dummy byte already belongs to the
    // first data slot.
    assign data_ack   = spi_tx_ack & ~cs_edge &
                        ((state == ST_RD_DATA) |
                         ((state == ST_RD_DUMMY) & spi_rx_stb));

    assign spi_tx_data = (state == ST_RD_DATA && tx_valid) ? tx_reg : TX_IDLE_BYTE;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        req       = 1'b0;
        req_we    = 1'b0;
        req_addr  = ptr;
        req_wdata = spi_rx_data;
        if (!cs_edge && !busy) begin
            case (state)
                ST_ADDR: begin
                    if (spi_rx_stb && is_read) begin
                        req      = 1'b1;
                        req_addr = spi_rx_data;
                    end
                end
                ST_WR_DATA: begin
                    if (spi_rx_stb) begin
                        req    = 1'b1;
                        req_we = 1'b1;
                    end
                end
                ST_RD_DUMMY, ST_RD_DATA: begin
                    req = rd_need;
                end
                default: ;
            endcase
        end
    end

    spi_dev_bus_ctl u_bus_ctl (
        .clk_slow  (clk_slow),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_cyc   (bus_cyc),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .busy      (busy),
        .done      (done),
        .done_we   (done_we),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk_slow) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ptr      <= 8'h00;
            tx_reg   <= TX_IDLE_BYTE;
            is_read  <= 1'b0;
            tx_valid <= 1'b0;
            rd_need  <= 1'b0;
            stale    <= 1'b0;
            err_ovr  <= 1'b0;
            err_udr  <= 1'b0;
        end else begin
            if (done) begin
                stale <= 1'b0;
            end
            if (frame_done) begin
                if (done_we) begin
                    ptr <= ptr_next(ptr);
                end else begin
                    tx_reg   <= rd_data;
                    tx_valid <= 1'b1;
                end
            end

            if (cs_edge) begin
                // Frame boundary: any still-running cycle finishes on the bus
                // but its result is dropped.
                state    <= spi_csn_fall ? ST_CMD : ST_IDLE;
                tx_valid <= 1'b0;
                rd_need  <= 1'b0;
                if (busy && !done) begin
                    stale <= 1'b1;
                end
                if (spi_csn_fall) begin
                    err_ovr <= 1'b0;
                    err_udr <= 1'b0;
                end
            end else begin
                if (req && !req_we && rd_need) begin
                    rd_need <= 1'b0;
                end
                case (state)
                    ST_CMD: begin
                        if (spi_rx_stb) begin
                            if (spi_rx_data == CMD_WR) begin
                                is_read <= 1'b0;
                                state   <= ST_ADDR;
                            end else if (spi_rx_data == CMD_RD) begin
                                is_read <= 1'b1;
                                state   <= ST_ADDR;
                            end else begin
                                state   <= ST_DISCARD;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (spi_rx_stb) begin
                            ptr   <= spi_rx_data;
                            state <= is_read ? ST_RD_DUMMY : ST_WR_DATA;
                            // Bus still owned by a previous frame: retry later.
                            if (is_read && busy) begin
                                rd_need <= 1'b1;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (spi_rx_stb && busy) begin
                            err_ovr <= 1'b1;
                        end
                    end
                    ST_RD_DUMMY: begin
                        if (spi_rx_stb) begin
                            state <= ST_RD_DATA;
                        end
                    end
                    default: ;
                endcase

                if (data_ack) begin
                    if (tx_valid) begin
                        tx_valid <= 1'b0;
                        ptr      <= ptr_next(ptr);
                        rd_need  <= 1'b1;
                    end else begin
                        err_udr  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_dev_reg_bridge.sv
// ----------------------------------------------------------------------------
// tb_spi_dev_reg_bridge
// Drives SPI-core side frames and models the register bus slave. Expected bus
// writes, read addresses and shifted-out bytes go into queues when stimulus
// is driven and are popped when the DUT produces them.
// ----------------------------------------------------------------------------
module tb_spi_dev_reg_bridge;

    logic       clk_slow;
    logic       rst;
    logic [7:0] spi_rx_data;
    logic       spi_rx_stb;
    logic [7:0] spi_tx_data;
    logic       spi_tx_ack;
    logic       spi_csn_rise;
    logic       spi_csn_fall;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_cyc;
    logic [7:0] bus_rdata;
    logic       bus_ack;
    logic       err_ovr;
    logic       err_udr;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mem [256];
    logic [15:0] exp_wr[$];     // {addr, data}
    logic [7:0]  exp_rd_addr[$];
    logic [7:0]  exp_tx[$];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          cyc_count = 0;

    spi_dev_reg_bridge dut (
        .clk_slow     (clk_slow),
        .rst          (rst),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_stb   (spi_rx_stb),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_ack   (spi_tx_ack),
        .spi_csn_rise (spi_csn_rise),
        .spi_csn_fall (spi_csn_fall),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_we       (bus_we),
        .bus_cyc      (bus_cyc),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .err_ovr      (err_ovr),
        .err_udr      (err_udr)
    );

    initial clk_slow = 1'b0;
    always #5 clk_slow = ~clk_slow;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Register bus slave: acks ack_delay cycles after bus_cyc is seen,
    // scoring every completed cycle against the expectation queues.
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            @(negedge clk_slow);
            bus_ack = 1'b0;
            if (bus_cyc === 1'b1) cyc_count++;
            if (bus_cyc === 1'b1 && rst === 1'b1) begin
                if (wait_cnt >= ack_delay) begin
                    wait_cnt = 0;
                    bus_ack  = 1'b1;
                    n_checks++;
                    if (bus_we) begin
                        mem[bus_addr] = bus_wdata;
                        if (exp_wr.size() == 0) begin
                            $display("FAIL bus_write: got %02h<=%02h, expected none", bus_addr, bus_wdata);
                        end else begin
                            logic [15:0] e;
                            e = exp_wr.pop_front();
                            if ({bus_addr, bus_wdata} !== e)
                                $display("FAIL bus_write: got %02h<=%02h, expected %02h<=%02h",
                                         bus_addr, bus_wdata, e[15:8], e[7:0]);
                            else n_pass++;
                        end
                    end else begin
                        bus_rdata = mem[bus_addr];
                        if (exp_rd_addr.size() == 0) begin
                            $display("FAIL bus_read: got addr %02h, expected none", bus_addr);
                        end else begin
                            logic [7:0] e;
                            e = exp_rd_addr.pop_front();
                            if (bus_addr !== e)
                                $display("FAIL bus_read: got addr %02h, expected %02h", bus_addr, e);
                            else n_pass++;
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic cs_fall();
        @(negedge clk_slow) spi_csn_fall = 1'b1;
        @(negedge clk_slow) spi_csn_fall = 1'b0;
    endtask

    task automatic cs_rise();
        @(negedge clk_slow) spi_csn_rise = 1'b1;
        @(negedge clk_slow) spi_csn_rise = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk_slow);
        spi_rx_data = b;
        spi_rx_stb  = 1'b1;
        @(negedge clk_slow) spi_rx_stb = 1'b0;
        repeat (gap) @(negedge clk_slow);
    endtask

    // Core loads spi_tx_data at the edge where the ack is sampled.
    task automatic tx_ack(input string name);
        logic [7:0] got;
        logic [7:0] e;
        @(negedge clk_slow);
        got = spi_tx_data;
        spi_tx_ack = 1'b1;
        @(negedge clk_slow) spi_tx_ack = 1'b0;
        n_checks++;
        if (exp_tx.size() == 0) begin
            $display("FAIL %s: shifted %02h with no expectation", name, got);
        end else begin
            e = exp_tx.pop_front();
            if (got !== e) $display("FAIL %s: shifted %02h, expected %02h", name, got, e);
            else n_pass++;
        end
    endtask

    task automatic wait_bus_idle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk_slow);
        while (bus_cyc === 1'b1 && n < budget) begin
            @(negedge clk_slow);
            n++;
        end
        n_checks++;
        if (bus_cyc !== 1'b0) $display("FAIL %s: bus_cyc still %b after %0d cycles", name, bus_cyc, budget);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk_slow);
        n_checks++;
        if ({bus_cyc, bus_we, err_ovr, err_udr} !== 4'b0000)
            $display("FAIL reset_flags: cyc/we/ovr/udr=%b, expected 0000", {bus_cyc, bus_we, err_ovr, err_udr});
        else n_pass++;
        n_checks++;
        if ({bus_addr, bus_wdata} !== 16'h0000)
            $display("FAIL reset_bus: addr/wdata=%04h, expected 0000", {bus_addr, bus_wdata});
        else n_pass++;
        n_checks++;
        if (spi_tx_data !== 8'hFF) $display("FAIL reset_tx: got %02h, expected FF", spi_tx_data);
        else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge clk_slow);
    endtask

    task automatic test_write();
        ack_delay = 0;
        exp_wr.push_back({8'h10, 8'hAA});
        exp_wr.push_back({8'h11, 8'hBB});
        cs_fall();
        send_byte(8'h02, 2);
        send_byte(8'h10, 2);
        send_byte(8'hAA, 3);
        send_byte(8'hBB, 3);
        cs_rise();
        wait_bus_idle("write_idle", 20);
        n_checks++;
        if (exp_wr.size() != 0) $display("FAIL write_count: %0d writes missing, expected 0", exp_wr.size());
        else n_pass++;
        n_checks++;
        if ({err_ovr, err_udr} !== 2'b00) $display("FAIL write_err: ovr/udr=%b, expected 00", {err_ovr, err_udr});
        else n_pass++;
    endtask

    task automatic test_read_wrap();
        ack_delay = 0;
        mem[8'hFE] = 8'h11;
        mem[8'hFF] = 8'h22;
        mem[8'h00] = 8'h33;
        mem[8'h01] = 8'h44;
        exp_rd_addr.push_back(8'hFE);
        exp_rd_addr.push_back(8'hFF);
        exp_rd_addr.push_back(8'h00);
        exp_rd_addr.push_back(8'h01);
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h22);
        exp_tx.push_back(8'h33);
        cs_fall();
        send_byte(8'h03, 2);
        send_byte(8'hFE, 2);
        send_byte(8'h00, 2);
        for (int i = 0; i < 3; i++) begin
            tx_ack("read_tx");
            repeat (5) @(negedge clk_slow);
        end
        cs_rise();
        wait_bus_idle("read_idle", 20);
        n_checks++;
        if (exp_rd_addr.size() != 0) $display("FAIL read_count: %0d reads missing, expected 0", exp_rd_addr.size());
        else n_pass++;
        n_checks++;
        if ({err_ovr, err_udr} !== 2'b00) $display("FAIL read_err: ovr/udr=%b, expected 00", {err_ovr, err_udr});
        else n_pass++;
    endtask

    task automatic test_overrun();
        ack_delay = 40;
        exp_wr.push_back({8'h20, 8'h5A});
        cs_fall();
        send_byte(8'h02, 2);
        send_byte(8'h20, 2);
        send_byte(8'h5A, 1);
        send_byte(8'h6B, 1);
        n_checks++;
        if (err_ovr !== 1'b1) $display("FAIL ovr_set: err_ovr=%b, expected 1", err_ovr);
        else n_pass++;
        wait_bus_idle("ovr_idle", 100);
        cs_rise();
        n_checks++;
        if (exp_wr.size() != 0 || err_ovr !== 1'b1)
            $display("FAIL ovr_sticky: missing=%0d err_ovr=%b, expected 0 and 1", exp_wr.size(), err_ovr);
        else n_pass++;
        cs_fall();
        n_checks++;
        if (err_ovr !== 1'b0) $display("FAIL ovr_clear: err_ovr=%b, expected 0", err_ovr);
        else n_pass++;
        cs_rise();
        ack_delay = 0;
    endtask

    task automatic test_underrun();
        ack_delay = 10;
        mem[8'h40] = 8'h77;
        exp_rd_addr.push_back(8'h40);
        exp_tx.push_back(8'hFF);
        cs_fall();
        send_byte(8'h03, 2);
        send_byte(8'h40, 0);
        send_byte(8'h00, 0);
        tx_ack("udr_tx");
        n_checks++;
        if (err_udr !== 1'b1) $display("FAIL udr_set: err_udr=%b, expected 1", err_udr);
        else n_pass++;
        wait_bus_idle("udr_idle", 40);
        // Late data is still delivered on the next slot; its follow-up read
        // is left in flight across chip-select rise and completes normally.
        exp_tx.push_back(8'h77);
        exp_rd_addr.push_back(8'h41);
        tx_ack("udr_late_tx");
        repeat (3) @(negedge clk_slow);
        cs_rise();
        wait_bus_idle("udr_idle2", 40);
        n_checks++;
        if (err_udr !== 1'b1 || exp_rd_addr.size() != 0)
            $display("FAIL udr_sticky: err_udr=%b missing=%0d, expected 1 and 0", err_udr, exp_rd_addr.size());
        else n_pass++;
        ack_delay = 0;
    endtask

    task automatic test_bad_opcode();
        int start_cyc;
        start_cyc = cyc_count;
        cs_fall();
        send_byte(8'h9F, 1);
        for (int i = 0; i < 3; i++) begin
            exp_tx.push_back(8'hFF);
            send_byte(8'h01 + 8'(i), 0);
            tx_ack("bad_op_tx");
        end
        cs_rise();
        n_checks++;
        if (cyc_count != start_cyc) $display("FAIL bad_op_cyc: %0d bus cycles, expected 0", cyc_count - start_cyc);
        else n_pass++;
        exp_wr.push_back({8'h30, 8'hC3});
        cs_fall();
        send_byte(8'h02, 2);
        send_byte(8'h30, 2);
        send_byte(8'hC3, 3);
        cs_rise();
        wait_bus_idle("bad_op_idle", 20);
        n_checks++;
        if (exp_wr.size() != 0) $display("FAIL bad_op_next: %0d writes missing, expected 0", exp_wr.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        ack_delay = 20;
        exp_tx.push_back(8'hFF);
        cs_fall();
        send_byte(8'h03, 2);
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        tx_ack("rst_mid_tx");
        cs_rise();
        repeat (2) @(negedge clk_slow);
        n_checks++;
        if (bus_cyc !== 1'b1 || err_udr !== 1'b1)
            $display("FAIL rst_mid_pending: cyc=%b udr=%b, expected 1 1", bus_cyc, err_udr);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk_slow);
        n_checks++;
        if ({bus_cyc, bus_we, err_ovr, err_udr, bus_addr, bus_wdata, spi_tx_data} !== {4'b0000, 16'h0000, 8'hFF})
            $display("FAIL rst_mid: cyc/we/ovr/udr=%b addr=%02h wdata=%02h tx=%02h, expected 0000 00 00 FF",
                     {bus_cyc, bus_we, err_ovr, err_udr}, bus_addr, bus_wdata, spi_tx_data);
        else n_pass++;
        @(negedge clk_slow) rst = 1'b1;
        repeat (3) @(negedge clk_slow);
        n_checks++;
        if (bus_cyc !== 1'b0) $display("FAIL rst_mid_after: bus_cyc=%b, expected 0", bus_cyc);
        else n_pass++;
        ack_delay = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst          = 1'b0;
        spi_rx_data  = 8'h00;
        spi_rx_stb   = 1'b0;
        spi_tx_ack   = 1'b0;
        spi_csn_rise = 1'b0;
        spi_csn_fall = 1'b0;

        test_reset();
        test_write();
        test_read_wrap();
        test_overrun();
        test_underrun();
        test_bad_opcode();
        test_reset_mid();

        n_checks++;
        if (exp_wr.size() + exp_rd_addr.size() + exp_tx.size() != 0)
            $display("FAIL scoreboard_drain: %0d entries left, expected 0",
                     exp_wr.size() + exp_rd_addr.size() + exp_tx.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
